// File: rtl/store_buffer.sv
// Posted-write store buffer: a circular FIFO of pending stores that drains on idle
// memory cycles, forwards buffered data to loads, and forces a drain after a load stall.
module store_buffer #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 4,
  parameter int MAX_STALL = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              ld_fwd_o,
  output logic              empty_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_writeData_o,
  input  logic [DATA_W-1:0] mem_readData_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STL_W = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [STL_W-1:0] STALL_MAX = STL_W'(MAX_STALL);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STL_W-1:0]  stall_q, stall_d;

  logic              push, pop, force_drain, is_empty;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  idx;

  assign is_empty    = (count_q == '0);
  assign empty_o     = is_empty;
  assign st_ready_o  = (count_q != CNT_FULL);
  assign force_drain = (stall_q == STALL_MAX) && !is_empty;
  assign push        = st_valid_i && st_ready_o;
  assign pop         = mem_write_o;

  always_comb begin
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_address_o   = '0;
    mem_writeData_o = '0;
    ld_ready_o      = 1'b1;
    if (force_drain) begin
      mem_write_o     = 1'b1;
      mem_address_o   = addr_q[head_q];
      mem_writeData_o = data_q[head_q];
      ld_ready_o      = 1'b0;
    end else if (ld_valid_i) begin
      mem_read_o    = 1'b1;
      mem_address_o = ld_addr_i;
    end else if (!is_empty) begin
      mem_write_o     = 1'b1;
      mem_address_o   = addr_q[head_q];
      mem_writeData_o = data_q[head_q];
    end
    // Registers clear asynchronously; the input-driven read path is masked as well.
    if (reset_i) begin
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      mem_address_o   = '0;
      mem_writeData_o = '0;
      ld_ready_o      = 1'b1;
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx] == ld_addr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign ld_fwd_o  = ld_valid_i && ld_ready_o && fwd_hit && !reset_i;
  assign ld_data_o = ld_fwd_o ? fwd_data : mem_readData_i;

  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
    stall_d = stall_q;
    if (pop || is_empty)                           stall_d = '0;
    else if (ld_valid_i && (stall_q != STALL_MAX)) stall_d = stall_q + STL_W'(1);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      addr_q[tail_q] <= st_addr_i;
      data_q[tail_q] <= st_data_i;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model with a per-cycle
// compare process, directed scenarios with literal expectations, then random traffic.
module tb_store_buffer;
  localparam int DEPTH     = 4;
  localparam int MAX_STALL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0, ld_valid = 1'b0;
  logic [63:0] st_addr = '0, st_data = '0, ld_addr = '0;
  logic        st_ready, ld_ready, ld_fwd, empty, mem_read, mem_write;
  logic [63:0] ld_data, mem_address, mem_wdata, mem_rdata;
  logic [63:0] mem [16];

  typedef struct packed { logic [63:0] a; logic [63:0] d; } ent_t;
  ent_t mq[$];
  int   m_stall = 0;
  int   n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  // DataMemory stand-in: 16 words, aliased on the low address bits.
  assign mem_rdata = mem_read ? mem[mem_address[3:0]] : 64'h0;
  always @(posedge clk) if (mem_write) mem[mem_address[3:0]] = mem_wdata;

  store_buffer #(.ADDR_W(64), .DATA_W(64), .DEPTH(DEPTH), .MAX_STALL(MAX_STALL)) dut (
    .clock_i(clk), .reset_i(rst),
    .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr), .st_data_i(st_data),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr), .ld_data_o(ld_data),
    .ld_fwd_o(ld_fwd), .empty_o(empty),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_address_o(mem_address),
    .mem_writeData_o(mem_wdata), .mem_readData_i(mem_rdata)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: expected outputs this cycle from the model queue and stall count.
  always @(negedge clk) begin
    int n; bit frc, e_mw, e_mr, e_ldr, hit; logic [63:0] e_addr, e_wd, e_ld;
    if (rst) begin
      check1("rst_st_ready", st_ready, 1'b1);
      check1("rst_ld_ready", ld_ready, 1'b1);
      check1("rst_empty", empty, 1'b1);
      check1("rst_mem_read", mem_read, 1'b0);
      check1("rst_mem_write", mem_write, 1'b0);
      check1("rst_ld_fwd", ld_fwd, 1'b0);
    end else begin
      n      = mq.size();
      frc    = (m_stall == MAX_STALL) && (n != 0);
      e_mw   = 1'b0; e_mr = 1'b0; e_ldr = 1'b1; e_addr = '0; e_wd = '0;
      if (frc) begin
        e_mw = 1'b1; e_ldr = 1'b0; e_addr = mq[0].a; e_wd = mq[0].d;
      end else if (ld_valid) begin
        e_mr = 1'b1; e_addr = ld_addr;
      end else if (n != 0) begin
        e_mw = 1'b1; e_addr = mq[0].a; e_wd = mq[0].d;
      end
      check1("st_ready", st_ready, n < DEPTH);
      check1("empty", empty, n == 0);
      check1("mem_write", mem_write, e_mw);
      check1("mem_read", mem_read, e_mr);
      check1("ld_ready", ld_ready, e_ldr);
      check64("mem_address", mem_address, e_addr);
      if (!e_mr) check64("mem_writeData", mem_wdata, e_wd);
      if (ld_valid && e_ldr) begin
        hit = 1'b0; e_ld = mem[ld_addr[3:0]];
        for (int i = n - 1; i >= 0; i--) begin
          if (mq[i].a == ld_addr) begin hit = 1'b1; e_ld = mq[i].d; break; end
        end
        check1("ld_fwd", ld_fwd, hit);
        check64("ld_data", ld_data, e_ld);
      end else begin
        check1("ld_fwd_idle", ld_fwd, 1'b0);
      end
    end
  end

  always @(posedge clk) begin
    int n; bit drain;
    if (rst) begin
      mq.delete();
      m_stall = 0;
    end else begin
      n     = mq.size();
      drain = (n != 0) && ((m_stall == MAX_STALL) || !ld_valid);
      if (drain) void'(mq.pop_front());
      if (st_valid && n < DEPTH) mq.push_back({st_addr, st_data});
      if (drain || n == 0) m_stall = 0;
      else if (ld_valid && m_stall < MAX_STALL) m_stall++;
    end
  end

  task automatic drive(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                       input logic lv, input logic [63:0] la);
    st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain_idle(input string name);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (empty) break;
      tick();
    end
    check1(name, empty, 1'b1);
    tick();
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [63:0] a;
    a = 64'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) a[40] = 1'b1;
    return a;
  endfunction

  initial begin
    bit st_pend, ld_pend; int ld_pct;
    for (int i = 0; i < 16; i++) mem[i] = 64'h1000 + 64'(i);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("init_empty", empty, 1'b1);
    check1("init_st_ready", st_ready, 1'b1);
    tick();

    // In-order drain of three stores, same address twice.
    drive(1'b1, 64'd3, 64'd5, 1'b0, 64'd0);
    @(negedge clk); check1("t2_c0_nowrite", mem_write, 1'b0); tick();
    drive(1'b1, 64'd7, 64'd9, 1'b0, 64'd0);
    @(negedge clk); check64("t2_w1_addr", mem_address, 64'd3); check64("t2_w1_data", mem_wdata, 64'd5); tick();
    drive(1'b1, 64'd3, 64'd11, 1'b0, 64'd0);
    @(negedge clk); check64("t2_w2_addr", mem_address, 64'd7); check64("t2_w2_data", mem_wdata, 64'd9); tick();
    drive(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    @(negedge clk); check64("t2_w3_addr", mem_address, 64'd3); check64("t2_w3_data", mem_wdata, 64'd11); tick();
    @(negedge clk); check1("t2_empty", empty, 1'b1); check64("t2_mem3", mem[3], 64'd11); tick();

    // Youngest-match forwarding, then a miss served by memory.
    drive(1'b1, 64'd3, 64'd5, 1'b1, 64'd9); tick();
    drive(1'b1, 64'd3, 64'd11, 1'b1, 64'd9); tick();
    drive(1'b0, 64'd0, 64'd0, 1'b1, 64'd3);
    @(negedge clk); check1("t3_fwd", ld_fwd, 1'b1); check64("t3_fwd_data", ld_data, 64'd11); tick();
    drive(1'b0, 64'd0, 64'd0, 1'b1, 64'd4);
    @(negedge clk); check1("t3_miss_fwd", ld_fwd, 1'b0); check64("t3_miss_data", ld_data, 64'h1004); tick();
    drain_idle("t3_drained");

    // Continuous load miss: buffer fills, starvation forces one drain.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 64'(10 + k), 64'(100 + k), 1'b1, 64'd1); tick();
    end
    drive(1'b1, 64'd14, 64'd104, 1'b1, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); check1("t4_full_st_ready", st_ready, 1'b0); check1("t4_ld_served", ld_ready, 1'b1); tick();
    end
    @(negedge clk);
    check1("t4_force_ld_ready", ld_ready, 1'b0);
    check1("t4_force_write", mem_write, 1'b1);
    check64("t4_force_addr", mem_address, 64'd10);
    tick();
    @(negedge clk); check1("t4_after_st_ready", st_ready, 1'b1); check1("t4_after_ld_ready", ld_ready, 1'b1); tick();
    drain_idle("t4_drained");

    // Push and drain together at count 2, pointers wrapping twice.
    drive(1'b1, 64'd40, 64'd200, 1'b1, 64'd1); tick();
    drive(1'b1, 64'd41, 64'd201, 1'b1, 64'd1); tick();
    for (int i = 2; i < 10; i++) begin
      drive(1'b1, 64'(40 + i), 64'(200 + i), 1'b0, 64'd0);
      @(negedge clk);
      check64("t5_addr", mem_address, 64'(40 + i - 2));
      check64("t5_data", mem_wdata, 64'(200 + i - 2));
      check1("t5_not_empty", empty, 1'b0);
      tick();
    end
    drain_idle("t5_drained");

    // Same-cycle store is invisible to the load; next cycle it forwards.
    drive(1'b1, 64'd5, 64'd77, 1'b1, 64'd5);
    @(negedge clk); check1("t6_same_fwd", ld_fwd, 1'b0); check64("t6_same_data", ld_data, 64'h1005); tick();
    drive(1'b0, 64'd0, 64'd0, 1'b1, 64'd5);
    @(negedge clk); check1("t6_next_fwd", ld_fwd, 1'b1); check64("t6_next_data", ld_data, 64'd77); tick();
    drain_idle("t6_drained");

    // Asynchronous reset mid-run discards buffered stores.
    drive(1'b1, 64'd6, 64'd55, 1'b1, 64'd1); tick();
    drive(1'b1, 64'd7, 64'd56, 1'b1, 64'd1); tick();
    #1 rst = 1'b1;
    #1;
    check1("t1_st_ready", st_ready, 1'b1);
    check1("t1_ld_ready", ld_ready, 1'b1);
    check1("t1_empty", empty, 1'b1);
    check1("t1_mem_read", mem_read, 1'b0);
    check1("t1_mem_write", mem_write, 1'b0);
    check1("t1_ld_fwd", ld_fwd, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    @(negedge clk); check1("t1_count0", empty, 1'b1); check64("t1_mem6_kept", mem[6], 64'h1006); tick();

    // Random traffic; stores and stalled loads are held until accepted.
    st_pend = 1'b0; ld_pend = 1'b0; ld_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) ld_pct = ($urandom_range(0, 1) == 0) ? 30 : 92;
      if (!st_pend) begin
        st_valid = ($urandom_range(0, 1) == 1);
        st_addr  = rnd_addr();
        st_data  = {$urandom, $urandom};
      end
      if (!ld_pend) begin
        ld_valid = ($urandom_range(0, 99) < ld_pct);
        ld_addr  = rnd_addr();
      end
      @(negedge clk);
      st_pend = st_valid && !st_ready;
      ld_pend = ld_valid && !ld_ready;
      tick();
    end
    drain_idle("rand_drained");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
